// File: rtl/xbar_rr_scheduler.sv
// Scheduler for a 3x3 packet switch: pops headers, arbitrates outputs round-robin,
// and sequences FIFO pops and mux selects for each packet payload.
module xbar_rr_scheduler #(
  parameter int unsigned DROP_CNT_W = 8,
  parameter int unsigned RR_INIT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic [7:0]            data1,
  input  logic [7:0]            data2,
  input  logic [7:0]            data3,
  output logic                  rdreq1,
  output logic                  rdreq2,
  output logic                  rdreq3,
  output logic [1:0]            sel1,
  output logic [1:0]            sel2,
  output logic [1:0]            sel3,
  output logic                  valid1,
  output logic                  valid2,
  output logic                  valid3,
  output logic                  eop1,
  output logic                  eop2,
  output logic                  eop3,
  output logic [2:0]            busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  typedef enum logic [2:0] {StIdle, StHdr, StReq, StXfer, StDrop} state_e;

  state_e                state_q [3];
  logic [1:0]            dest_q  [3];
  logic [5:0]            rem_q   [3];
  logic [1:0]            sel_q   [3];
  logic [1:0]            ptr_q   [3];
  logic [2:0]            valid_q, eop_q;
  logic [DROP_CNT_W-1:0] drop_q;

  logic [2:0]            empty, rdreq, granted, drop_ev;
  logic [2:0]            valid_d, eop_d;
  logic [7:0]            data [3];
  logic [1:0]            gnt  [3];
  logic [DROP_CNT_W+1:0] drop_sum;
  logic [DROP_CNT_W-1:0] drop_d;

  assign empty   = {empty3, empty2, empty1};
  assign data[0] = data1;
  assign data[1] = data2;
  assign data[2] = data3;

  // Input index visited k steps after pointer ptr (ptr is 1-based, result 0-based).
  function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int k);
    int s;
    s = int'(ptr) - 1 + k;
    return 2'(s % 3);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdreq[i] = 1'b0;
      case (state_q[i])
        StIdle:         rdreq[i] = !empty[i];
        StXfer, StDrop: rdreq[i] = (rem_q[i] != 6'd0) && !empty[i];
        default:        rdreq[i] = 1'b0;
      endcase
      if (!reset) rdreq[i] = 1'b0;
      drop_ev[i] = ((state_q[i] == StHdr) && (data[i][7:2] == 6'd0)) ||
                   ((state_q[i] == StDrop) && (rem_q[i] == 6'd0));
    end
  end

  // An output is free exactly when its select is zero.
  always_comb begin
    granted = 3'b000;
    for (int o = 0; o < 3; o++) begin
      gnt[o] = 2'd0;
      if (sel_q[o] == 2'd0) begin
        for (int k = 0; k < 3; k++) begin
          if ((gnt[o] == 2'd0) && (state_q[rr_idx(ptr_q[o], k)] == StReq) &&
              (dest_q[rr_idx(ptr_q[o], k)] == 2'(o + 1))) begin
            gnt[o] = rr_idx(ptr_q[o], k) + 2'd1;
          end
        end
      end
      if (gnt[o] != 2'd0) granted[gnt[o] - 2'd1] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < 3; o++) begin
      valid_d[o] = 1'b0;
      eop_d[o]   = 1'b0;
      if (sel_q[o] != 2'd0) begin
        valid_d[o] = rdreq[sel_q[o] - 2'd1];
        eop_d[o]   = rdreq[sel_q[o] - 2'd1] && (rem_q[sel_q[o] - 2'd1] == 6'd1);
      end
    end
  end

  always_comb begin
    drop_sum = {2'b00, drop_q} + (DROP_CNT_W + 2)'(drop_ev[0]) +
               (DROP_CNT_W + 2)'(drop_ev[1]) + (DROP_CNT_W + 2)'(drop_ev[2]);
    drop_d   = (drop_sum > {2'b00, {DROP_CNT_W{1'b1}}}) ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StIdle;
        dest_q[i]  <= 2'd0;
        rem_q[i]   <= 6'd0;
        sel_q[i]   <= 2'd0;
        ptr_q[i]   <= 2'(RR_INIT);
      end
      valid_q <= 3'b000;
      eop_q   <= 3'b000;
      drop_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (state_q[i])
          StIdle: if (rdreq[i]) state_q[i] <= StHdr;
          StHdr: begin
            dest_q[i] <= data[i][1:0];
            rem_q[i]  <= data[i][7:2];
            if (data[i][7:2] == 6'd0)      state_q[i] <= StIdle;
            else if (data[i][1:0] == 2'd0) state_q[i] <= StDrop;
            else                           state_q[i] <= StReq;
          end
          StReq: if (granted[i]) state_q[i] <= StXfer;
          StXfer, StDrop: begin
            if (rdreq[i])                 rem_q[i]   <= rem_q[i] - 6'd1;
            else if (rem_q[i] == 6'd0)    state_q[i] <= StIdle;
          end
          default: state_q[i] <= StIdle;
        endcase
      end
      for (int o = 0; o < 3; o++) begin
        if (gnt[o] != 2'd0) begin
          sel_q[o] <= gnt[o];
          ptr_q[o] <= (gnt[o] == 2'd3) ? 2'd1 : gnt[o] + 2'd1;
        end else if ((sel_q[o] != 2'd0) && (rem_q[sel_q[o] - 2'd1] == 6'd0)) begin
          sel_q[o] <= 2'd0;
        end
      end
      valid_q <= valid_d;
      eop_q   <= eop_d;
      drop_q  <= drop_d;
    end
  end

  assign {rdreq3, rdreq2, rdreq1} = rdreq;
  assign sel1       = sel_q[0];
  assign sel2       = sel_q[1];
  assign sel3       = sel_q[2];
  assign {valid3, valid2, valid1} = valid_q;
  assign {eop3, eop2, eop1}       = eop_q;
  assign busy       = {state_q[2] != StIdle, state_q[1] != StIdle, state_q[0] != StIdle};
  assign drop_count = drop_q;

endmodule

// File: tb/tb_xbar_rr_scheduler.sv
// Directed bench for xbar_rr_scheduler with behavioural FIFOs and output muxes.
module tb_xbar_rr_scheduler;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       empty1, empty2, empty3;
  logic [7:0] data1 = 8'h00, data2 = 8'h00, data3 = 8'h00;
  logic       rdreq1, rdreq2, rdreq3;
  logic [1:0] sel1, sel2, sel3;
  logic       valid1, valid2, valid3;
  logic       eop1, eop2, eop3;
  logic [2:0] busy;
  logic [7:0] drop_count;
  logic [7:0] result1, result2, result3;

  logic [7:0] mem [3][1024];
  int wr_ptr [3] = '{0, 0, 0};
  int rd_ptr [3] = '{0, 0, 0};
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  xbar_rr_scheduler #(.DROP_CNT_W(8), .RR_INIT(1)) dut (
    .clk(clk), .reset(reset),
    .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .data1(data1), .data2(data2), .data3(data3),
    .rdreq1(rdreq1), .rdreq2(rdreq2), .rdreq3(rdreq3),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .eop1(eop1), .eop2(eop2), .eop3(eop3),
    .busy(busy), .drop_count(drop_count)
  );

  assign empty1 = (wr_ptr[0] == rd_ptr[0]);
  assign empty2 = (wr_ptr[1] == rd_ptr[1]);
  assign empty3 = (wr_ptr[2] == rd_ptr[2]);

  function automatic logic [7:0] mux(input logic [1:0] s, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] c);
    case (s)
      2'd1:    return a;
      2'd2:    return b;
      2'd3:    return c;
      default: return 8'h00;
    endcase
  endfunction

  assign result1 = mux(sel1, data1, data2, data3);
  assign result2 = mux(sel2, data1, data2, data3);
  assign result3 = mux(sel3, data1, data2, data3);

  // Show-ahead-free FIFO model; software flush is modelled while reset is held.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) rd_ptr[i] <= wr_ptr[i];
    end else begin
      if (rdreq1) begin data1 <= mem[0][rd_ptr[0] % 1024]; rd_ptr[0] <= rd_ptr[0] + 1; end
      if (rdreq2) begin data2 <= mem[1][rd_ptr[1] % 1024]; rd_ptr[1] <= rd_ptr[1] + 1; end
      if (rdreq3) begin data3 <= mem[2][rd_ptr[2] % 1024]; rd_ptr[2] <= rd_ptr[2] + 1; end
    end
  end

  task automatic push(input int f, input logic [7:0] b);
    mem[f][wr_ptr[f] % 1024] = b;
    wr_ptr[f] = wr_ptr[f] + 1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    @(negedge clk);
    push(0, 8'h0E);
    #1;
    total++;
    if (rdreq1 !== 1'b0) begin
      bad++; $display("FAIL reset_rdreq1 got=%b exp=0", rdreq1);
    end
    total++;
    if ({sel1, sel2, sel3, valid1, valid2, valid3, eop1, eop2, eop3} !== 12'h000) begin
      bad++; $display("FAIL reset_outputs got=%h exp=000",
                      {sel1, sel2, sel3, valid1, valid2, valid3, eop1, eop2, eop3});
    end
    total++;
    if ({busy, drop_count} !== 11'h000) begin
      bad++; $display("FAIL reset_busy_drop got=%h exp=000", {busy, drop_count});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single;
    logic [7:0] m_rd, m_sel, m_val, m_eop, exp_res;
    m_rd = 8'b0011_1001; m_sel = 8'b0111_1000; m_val = 8'b0111_0000; m_eop = 8'b0100_0000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin push(0, 8'h0E); push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3); end
      #1;
      total++;
      if (rdreq1 !== m_rd[c]) begin
        bad++; $display("FAIL single_rdreq1 c=%0d got=%b exp=%b", c, rdreq1, m_rd[c]);
      end
      total++;
      if (sel2 !== (m_sel[c] ? 2'd1 : 2'd0)) begin
        bad++; $display("FAIL single_sel2 c=%0d got=%0d exp=%0d", c, sel2, m_sel[c]);
      end
      total++;
      if ({valid1, valid2, valid3, eop2} !== {1'b0, m_val[c], 1'b0, m_eop[c]}) begin
        bad++; $display("FAIL single_valid_eop c=%0d got=%b exp=%b", c,
                        {valid1, valid2, valid3, eop2}, {1'b0, m_val[c], 1'b0, m_eop[c]});
      end
      if (m_val[c]) begin
        exp_res = (c == 4) ? 8'hA1 : (c == 5) ? 8'hA2 : 8'hA3;
        total++;
        if (result2 !== exp_res) begin
          bad++; $display("FAIL single_result2 c=%0d got=%h exp=%h", c, result2, exp_res);
        end
      end
    end
  endtask

  task automatic test_rr_contention;
    logic [1:0] exp_sel;
    logic       exp_v, exp_e;
    logic [7:0] exp_res;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 0) begin
        push(0, 8'h0B); push(0, 8'h11); push(0, 8'h12);
        push(1, 8'h0B); push(1, 8'h21); push(1, 8'h22);
        push(2, 8'h0B); push(2, 8'h31); push(2, 8'h32);
      end
      #1;
      exp_sel = (c >= 3 && c <= 5) ? 2'd1 : (c >= 7 && c <= 9) ? 2'd2 :
                (c >= 11 && c <= 13) ? 2'd3 : 2'd0;
      exp_v   = (c == 4 || c == 5 || c == 8 || c == 9 || c == 12 || c == 13);
      exp_e   = (c == 5 || c == 9 || c == 13);
      total++;
      if (sel3 !== exp_sel) begin
        bad++; $display("FAIL rr_sel3 c=%0d got=%0d exp=%0d", c, sel3, exp_sel);
      end
      total++;
      if ({valid3, eop3} !== {exp_v, exp_e}) begin
        bad++; $display("FAIL rr_valid_eop3 c=%0d got=%b exp=%b", c, {valid3, eop3}, {exp_v, exp_e});
      end
      if (exp_v) begin
        exp_res = {2'b00, exp_sel, 3'b000, !exp_e};
        exp_res = (exp_sel == 2'd1) ? (exp_e ? 8'h12 : 8'h11) :
                  (exp_sel == 2'd2) ? (exp_e ? 8'h22 : 8'h21) : (exp_e ? 8'h32 : 8'h31);
        total++;
        if (result3 !== exp_res) begin
          bad++; $display("FAIL rr_result3 c=%0d got=%h exp=%h", c, result3, exp_res);
        end
      end
    end
    // Pointer should have wrapped back to input 1.
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin push(1, 8'h07); push(1, 8'h72); push(0, 8'h07); push(0, 8'h71); end
      #1;
      exp_sel = (c == 3 || c == 4) ? 2'd1 : (c == 6 || c == 7) ? 2'd2 : 2'd0;
      total++;
      if (sel3 !== exp_sel) begin
        bad++; $display("FAIL rr_wrap_sel3 c=%0d got=%0d exp=%0d", c, sel3, exp_sel);
      end
      if (c == 4 || c == 7) begin
        exp_res = (c == 4) ? 8'h71 : 8'h72;
        total++;
        if ({valid3, eop3, result3} !== {2'b11, exp_res}) begin
          bad++; $display("FAIL rr_wrap_byte c=%0d got=%b%b_%h exp=11_%h", c, valid3, eop3,
                          result3, exp_res);
        end
      end
    end
  endtask

  task automatic test_drop;
    logic [7:0] m_rd, exp_cnt;
    m_rd = 8'b0010_1101;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin push(1, 8'h08); push(1, 8'hB1); push(1, 8'hB2); push(1, 8'h00); end
      #1;
      exp_cnt = (c < 5) ? 8'd0 : (c < 7) ? 8'd1 : 8'd2;
      total++;
      if (rdreq2 !== m_rd[c]) begin
        bad++; $display("FAIL drop_rdreq2 c=%0d got=%b exp=%b", c, rdreq2, m_rd[c]);
      end
      total++;
      if ({sel1, sel2, sel3, valid1, valid2, valid3} !== 9'h000) begin
        bad++; $display("FAIL drop_no_output c=%0d got=%h exp=000", c,
                        {sel1, sel2, sel3, valid1, valid2, valid3});
      end
      total++;
      if (drop_count !== exp_cnt) begin
        bad++; $display("FAIL drop_count c=%0d got=%0d exp=%0d", c, drop_count, exp_cnt);
      end
    end
    total++;
    if ({empty2, busy} !== 4'b1000) begin
      bad++; $display("FAIL drop_idle got=%b exp=1000", {empty2, busy});
    end
  endtask

  task automatic test_stall;
    logic [15:0] m_rd, m_sel, m_val, m_eop;
    logic [7:0]  exp_res;
    m_rd = 16'h0C19; m_sel = 16'h1FF8; m_val = 16'h1830; m_eop = 16'h1000;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 0)  begin push(0, 8'h11); push(0, 8'hC1); push(0, 8'hC2); end
      if (c == 10) begin push(0, 8'hC3); push(0, 8'hC4); end
      #1;
      total++;
      if (rdreq1 !== m_rd[c]) begin
        bad++; $display("FAIL stall_rdreq1 c=%0d got=%b exp=%b", c, rdreq1, m_rd[c]);
      end
      total++;
      if (sel1 !== (m_sel[c] ? 2'd1 : 2'd0)) begin
        bad++; $display("FAIL stall_sel1 c=%0d got=%0d exp=%0d", c, sel1, m_sel[c]);
      end
      total++;
      if ({valid1, eop1} !== {m_val[c], m_eop[c]}) begin
        bad++; $display("FAIL stall_valid_eop1 c=%0d got=%b exp=%b", c, {valid1, eop1},
                        {m_val[c], m_eop[c]});
      end
      if (m_val[c]) begin
        exp_res = (c == 4) ? 8'hC1 : (c == 5) ? 8'hC2 : (c == 11) ? 8'hC3 : 8'hC4;
        total++;
        if (result1 !== exp_res) begin
          bad++; $display("FAIL stall_result1 c=%0d got=%h exp=%h", c, result1, exp_res);
        end
      end
    end
  endtask

  task automatic test_concurrent_reset;
    logic       exp_on, exp_v, exp_e;
    logic [7:0] exp_a, exp_b;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        push(0, 8'h0F); push(0, 8'hD1); push(0, 8'hD2); push(0, 8'hD3);
        push(1, 8'h0D); push(1, 8'hE1); push(1, 8'hE2); push(1, 8'hE3);
      end
      #1;
      exp_on = (c >= 3 && c <= 6);
      exp_v  = (c >= 4 && c <= 6);
      exp_e  = (c == 6);
      total++;
      if ({sel1, sel3} !== (exp_on ? 4'b1001 : 4'b0000)) begin
        bad++; $display("FAIL conc_sel c=%0d got=%b exp_on=%b", c, {sel1, sel3}, exp_on);
      end
      total++;
      if ({valid1, eop1, valid3, eop3, valid2} !== {exp_v, exp_e, exp_v, exp_e, 1'b0}) begin
        bad++; $display("FAIL conc_valid_eop c=%0d got=%b exp=%b", c,
                        {valid1, eop1, valid3, eop3, valid2}, {exp_v, exp_e, exp_v, exp_e, 1'b0});
      end
      if (exp_v) begin
        exp_a = (c == 4) ? 8'hD1 : (c == 5) ? 8'hD2 : 8'hD3;
        exp_b = (c == 4) ? 8'hE1 : (c == 5) ? 8'hE2 : 8'hE3;
        total++;
        if ({result3, result1} !== {exp_a, exp_b}) begin
          bad++; $display("FAIL conc_result c=%0d got=%h exp=%h", c, {result3, result1},
                          {exp_a, exp_b});
        end
      end
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        push(0, 8'h16);
        for (int k = 1; k <= 5; k++) push(0, 8'hF0 + 8'(k));
      end
      #1;
    end
    total++;
    if ({sel2, valid2, drop_count} !== {2'd1, 1'b1, 8'd2}) begin
      bad++; $display("FAIL pre_reset got=%h exp=%h", {sel2, valid2, drop_count},
                      {2'd1, 1'b1, 8'd2});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({sel1, sel2, sel3, valid1, valid2, valid3, eop1, eop2, eop3} !== 12'h000) begin
      bad++; $display("FAIL async_reset_outputs got=%h exp=000",
                      {sel1, sel2, sel3, valid1, valid2, valid3, eop1, eop2, eop3});
    end
    total++;
    if ({rdreq1, busy, drop_count} !== 12'h000) begin
      bad++; $display("FAIL async_reset_state got=%h exp=000", {rdreq1, busy, drop_count});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({rdreq1, busy} !== 4'b0000) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=0000", {rdreq1, busy});
    end
  endtask

  task automatic test_drop_saturate;
    int   cyc;
    logic done, saw_valid;
    cyc = 0; done = 1'b0; saw_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 260; k++) push(2, k[0] ? 8'h02 : 8'h00);
    #1;
    while (!done && cyc < 1500) begin
      @(negedge clk);
      #1;
      cyc++;
      if (valid1 || valid2 || valid3) saw_valid = 1'b1;
      if (empty3 && busy == 3'b000) done = 1'b1;
    end
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL sat_timeout got=%b exp=1 cycles=%0d", done, cyc);
    end
    total++;
    if (drop_count !== 8'hFF) begin
      bad++; $display("FAIL sat_drop_count got=%0d exp=255", drop_count);
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++; $display("FAIL sat_no_valid got=%b exp=0", saw_valid);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_rr_contention;
    test_drop;
    test_stall;
    test_concurrent_reset;
    test_drop_saturate;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xbar_rr_scheduler.md
Name: xbar_rr_scheduler

Overview:
- Sequences the three input FIFOs and three output muxes of the 3x3 packet switch.
- Pops each packet header and decodes the destination.
- Arbitrates contending inputs per output port with round-robin priority, and drives FIFO read requests and mux selects for the payload.
- Counts packets dropped for an invalid destination.

Parameters:
- DROP_CNT_W, 8: width of the saturating drop counter.
- RR_INIT, 1: initial round-robin pointer of each output (1..3).

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset (asserted when 0).
- empty1..empty3, in, 1 each: FIFO i empty.
- data1..data3, in, 8 each: FIFO i q. Normal mode: q is valid the cycle after rdreq and holds until the next rdreq.
- rdreq1..rdreq3, out, 1 each: FIFO i pop.
- sel1..sel3, out, 2 each: output o mux select. 0 = idle/zero, i = input i.
- valid1..valid3, out, 1 each: result_o carries a payload byte this cycle.
- eop1..eop3, out, 1 each: the valid byte is the last of its packet.
- busy, out, 3: bit i-1 set while input i's FSM is not IDLE.
- drop_count, out, DROP_CNT_W: saturating count of dropped packets.

Behaviour:
- Header byte format:
  - [1:0] = destination output (1..3); 0 = drop.
  - [7:2] = payload length LEN (0..63).
  - The header is consumed, never forwarded.
- Reset values: all FSMs IDLE; rdreq = 0, sel = 0, valid = 0, eop = 0, busy = 0, drop_count = 0; RR pointers = RR_INIT.
- Input FSM, per input i. rdreq_i is combinational from registered state and empty_i.
  - IDLE: if !empty_i, assert rdreq_i and go to HDR.
  - HDR: latch data_i into dest and rem = LEN.
    - dest = 0 and LEN = 0: increment drop_count, go to IDLE.
    - dest = 0 and LEN > 0: go to DROP.
    - dest != 0 and LEN = 0: increment drop_count, go to IDLE.
    - Otherwise: go to REQ.
  - REQ: request output dest. On grant, register sel_dest <= i and go to XFER. Otherwise stay.
  - XFER:
    - If rem > 0 and !empty_i: assert rdreq_i, rem--.
    - If rem > 0 and empty_i: stall; no rdreq, sel held.
    - If rem = 0: the last byte is on result this cycle. At the clock edge, clear sel_dest to 0, release the output, go to IDLE.
  - DROP: same pop rule as XFER, with no sel and no valid. When rem = 0, increment drop_count and go to IDLE.
- Output side:
  - valid_o and eop_o are registered from the granted input's rdreq, delayed 1 cycle, aligned with the byte on result_o.
  - eop_o is set when the pop that produced the byte took rem from 1 to 0.
- Arbitration, per output o:
  - Free when no input holds it in XFER.
  - Requesters are inputs in REQ whose dest = o.
  - Grant goes to the first requester searching from pointer p_o upward, wrapping 3 -> 1.
  - On grant to input i, p_o <= i+1, wrapping 3 -> 1.
  - Grant is evaluated in the REQ cycle and takes effect at that edge.
  - One grant per output per cycle. A single input requests only one output, so no input-side conflict exists.
- Latency, empty FIFOs otherwise:
  - Cycle 0: header pop (IDLE).
  - Cycle 1: HDR.
  - Cycle 2: REQ/grant.
  - Cycle 3: first payload pop.
  - Cycle 4: first valid.
  - Full-rate payload: one byte per cycle.
- Boundaries:
  - drop_count saturates at all-ones.
  - Different outputs transfer concurrently and independently.
  - Reset mid-packet aborts immediately. FIFOs are not flushed: residual payload bytes are parsed as headers after reset. Software must flush.

Test Plan:
- Input 1 gets 0x0E (dest 2, LEN 3), 0xA1, 0xA2, 0xA3 -> rdreq1 at cycles 0, 3, 4, 5; sel2 = 1 in cycles 3..6; valid2 at 4..6 with result2 = A1, A2, A3; eop2 only at 6; sel2 = 0 at 7.
- Inputs 1, 2, 3 each enqueue a LEN-2 packet to output 3 simultaneously, RR_INIT = 1 -> grants in order 1, 2, 3; each next grant the cycle after the previous release; p3 ends at 1.
- Input 2 packet 0x08 (dest 0, LEN 2) + 2 bytes, then 0x00 -> both dropped, no valid on any output, drop_count = 2, FIFO2 empty.
- Input 1 dest 1 LEN 4 with the FIFO emptying after 2 payload bytes for 5 cycles -> no rdreq and no valid during the gap, sel1 = 1 held; remaining 2 bytes are forwarded with eop on the 4th.
- Concurrent 1 -> 3 and 2 -> 1 transfers -> both proceed at full rate in parallel, independent eops. Reset asserted mid-transfer -> all outputs 0 asynchronously, drop_count = 0.
- Drive 260 invalid-dest packets -> drop_count stays at 255.
